wb_burst_master: RTL

// Pipelined Wishbone initiator driving one port of the dual-port RAM subsystem (e.g. a DMA or test-engine port).

---
 rtl/wb_burst_master.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// Pipelined Wishbone burst initiator: incrementing word beats, bounded
// outstanding requests, registered read return and ack-timeout abort.
module wb_burst_master #(
    parameter int MAX_OUT        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [10:0] cmd_addr_i,
    input  logic [7:0]  cmd_len_i,
    input  logic [3:0]  cmd_be_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    input  logic [31:0] wdata_i,
    output logic        rdata_valid_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [3:0]  wb_we_o,
    output logic [10:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_data_i
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    MAXO     = 4'(MAX_OUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic          write_q, write_d;
    logic [3:0]    be_q, be_d;
    logic [10:0]   addr_q, addr_d;
    logic [8:0]    left_q, left_d;
    logic [2:0]    out_q, out_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic [3:0]    we_q, we_d;
    logic [10:0]   wba_q, wba_d;
    logic [31:0]   wbd_q, wbd_d;
    logic          rv_q, rv_d;
    logic [31:0]   rd_q, rd_d;

    logic accept, ack_v, cmd_acc, tmo_hit;
    logic slot_free, load, busy;

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign accept    = stb_q && !wb_stall_i;
    assign ack_v     = wb_ack_i && (out_q != 3'd0);
    assign cmd_acc   = cmd_valid_i && ready_q;
    assign tmo_hit   = cyc_q && !wb_ack_i && !accept
                       && (tmo_q == TMO_LAST);
    // A same-cycle ack does not free its slot until next cycle.
    assign slot_free = ({1'b0, out_q} + {3'b000, stb_q}) < MAXO;
    assign load      = (state_q == S_RUN)
                       && (!stb_q || !wb_stall_i)
                       && (left_q != 9'd0)
                       && slot_free
                       && (!write_q || wdata_valid_i)
                       && !tmo_hit;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        be_d    = be_q;
        addr_d  = addr_q;
        left_d  = left_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        wba_d   = wba_q;
        wbd_d   = wbd_q;
        out_d   = out_q;
        if (accept && !ack_v) begin
            out_d = out_q + 3'd1;
        end else if (!accept && ack_v) begin
            out_d = out_q - 3'd1;
        end
        if (!cyc_q || wb_ack_i || accept) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        rv_d = ack_v && busy && !write_q;
        rd_d = rv_d ? wb_data_i : 32'd0;

        if (load) begin
            stb_d  = 1'b1;
            we_d   = write_q ? be_q : 4'b0000;
            wba_d  = addr_q;
            wbd_d  = write_q ? wdata_i : 32'd0;
            addr_d = addr_q + 11'd4;
            left_d = left_q - 9'd1;
        end else if (accept) begin
            stb_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    write_d = cmd_write_i;
                    be_d    = cmd_be_i;
                    addr_d  = cmd_addr_i & 11'h7FC;
                    left_d  = {1'b0, cmd_len_i} + 9'd1;
                    if (cmd_write_i && (cmd_be_i == 4'b0000)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_RUN;
                        cyc_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (tmo_hit) begin
                    state_d = S_ERR;
                end else if (accept && (left_q == 9'd0)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tmo_hit) begin
                    state_d = S_ERR;
                end else if (ack_v && (out_q == 3'd1)) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort drops the bus and forgets any beats still owed.
        if (state_d == S_ERR) begin
            cyc_d  = 1'b0;
            stb_d  = 1'b0;
            out_d  = 3'd0;
            left_d = 9'd0;
        end
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 11'd0;
            left_q  <= 9'd0;
            out_q   <= 3'd0;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 4'b0000;
            wba_q   <= 11'd0;
            wbd_q   <= 32'd0;
            rv_q    <= 1'b0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            write_q <= write_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            out_q   <= out_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            wba_q   <= wba_d;
            wbd_q   <= wbd_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
        end
    end

    assign cmd_ready_o   = ready_q;
    assign wdata_ready_o = load && write_q;
    assign rdata_valid_o = rv_q;
    assign rdata_o       = rd_q;
    assign done_o        = (state_q == S_DONE);
    assign err_o         = (state_q == S_ERR);
    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = stb_q;
    assign wb_we_o       = we_q;
    assign wb_addr_o     = wba_q;
    assign wb_data_o     = wbd_q;
endmodule
